// File: rtl/rvh_l1d_req_arb.sv
// L1D request arbiter: grants one of PTW/LD/ST into a single stage-1 register.
// Optional store starvation guard enabled by defining RVH_L1D_ARB_STARVE_GUARD_EN.
module rvh_l1d_req_arb #(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_req_vld_i,
  output logic                  ld_req_rdy_o,
  input  logic [2:0]            ld_req_opcode_i,
  input  logic [ADDR_WIDTH-1:0] ld_req_addr_i,
  input  logic [TAG_WIDTH-1:0]  ld_req_tag_i,
  input  logic                  st_req_vld_i,
  output logic                  st_req_rdy_o,
  input  logic [4:0]            st_req_opcode_i,
  input  logic [ADDR_WIDTH-1:0] st_req_addr_i,
  input  logic [63:0]           st_req_data_i,
  input  logic [TAG_WIDTH-1:0]  st_req_tag_i,
  input  logic                  ptw_req_vld_i,
  output logic                  ptw_req_rdy_o,
  input  logic [ADDR_WIDTH-1:0] ptw_req_addr_i,
  input  logic                  flush_i,
  output logic                  is_ld_req_vld_o,
  output logic                  is_st_req_vld_o,
  output logic                  is_ptw_req_vld_o,
  output logic [2:0]            s1_ld_opcode_o,
  output logic [4:0]            s1_st_opcode_o,
  output logic [ADDR_WIDTH-1:0] s1_addr_o,
  output logic [63:0]           s1_data_o,
  output logic [TAG_WIDTH-1:0]  s1_tag_o,
  input  logic                  s1_rdy_i
);

  logic held;
  logic free;
  logic ld_ok;
  logic ld_grant;
  logic st_grant;
  logic ptw_grant;
  logic st_promote;

  assign held  = is_ld_req_vld_o | is_st_req_vld_o | is_ptw_req_vld_o;
  assign free  = ~held | s1_rdy_i;
  assign ld_ok = ld_req_vld_i & ~flush_i;

`ifdef RVH_L1D_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign st_promote = (starve_cnt == CNT_W'(STARVE_MAX));

  // Counts cycles a pending store loses; saturates so promotion persists until granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!st_req_vld_i || st_grant) begin
      starve_cnt <= '0;
    end else if (!st_promote) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  assign st_promote = 1'b0;
`endif

  always_comb begin
    ld_grant  = 1'b0;
    st_grant  = 1'b0;
    ptw_grant = 1'b0;
    if (free) begin
      if (st_promote && st_req_vld_i) st_grant  = 1'b1;
      else if (ptw_req_vld_i)         ptw_grant = 1'b1;
      else if (ld_ok)                 ld_grant  = 1'b1;
      else if (st_req_vld_i)          st_grant  = 1'b1;
    end
  end

  // Ready is suppressed while reset is held so no transfer can complete in that cycle.
  assign ld_req_rdy_o  = ld_grant  & rst_n;
  assign st_req_rdy_o  = st_grant  & rst_n;
  assign ptw_req_rdy_o = ptw_grant & rst_n;

  // Stage-1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_ld_req_vld_o  <= 1'b0;
      is_st_req_vld_o  <= 1'b0;
      is_ptw_req_vld_o <= 1'b0;
      s1_ld_opcode_o   <= '0;
      s1_st_opcode_o   <= '0;
      s1_addr_o        <= '0;
      s1_data_o        <= '0;
      s1_tag_o         <= '0;
    end else if (free) begin
      is_ld_req_vld_o  <= ld_grant;
      is_st_req_vld_o  <= st_grant;
      is_ptw_req_vld_o <= ptw_grant;
      s1_ld_opcode_o   <= ld_grant ? ld_req_opcode_i : '0;
      s1_st_opcode_o   <= st_grant ? st_req_opcode_i : '0;
      s1_data_o        <= st_grant ? st_req_data_i : '0;
      s1_addr_o        <= ptw_grant ? ptw_req_addr_i :
                          ld_grant  ? ld_req_addr_i  :
                          st_grant  ? st_req_addr_i  : '0;
      s1_tag_o         <= ld_grant ? ld_req_tag_i :
                          st_grant ? st_req_tag_i : '0;
    end else if (is_ld_req_vld_o && flush_i) begin
      // A stalled load is killed by flush even though downstream has not taken it.
      is_ld_req_vld_o  <= 1'b0;
      s1_ld_opcode_o   <= '0;
      s1_addr_o        <= '0;
      s1_tag_o         <= '0;
    end
  end

endmodule

// File: tb/tb_rvh_l1d_req_arb.sv
// Directed testbench for rvh_l1d_req_arb; the starvation test adapts to RVH_L1D_ARB_STARVE_GUARD_EN.
module tb_rvh_l1d_req_arb;
  localparam int AW = 40;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_vld, ld_rdy;
  logic [2:0]    ld_op;
  logic [AW-1:0] ld_addr;
  logic [TW-1:0] ld_tag;
  logic          st_vld, st_rdy;
  logic [4:0]    st_op;
  logic [AW-1:0] st_addr;
  logic [63:0]   st_data;
  logic [TW-1:0] st_tag;
  logic          ptw_vld, ptw_rdy;
  logic [AW-1:0] ptw_addr;
  logic          flush;
  logic          is_ld, is_st, is_ptw;
  logic [2:0]    s1_ld_op;
  logic [4:0]    s1_st_op;
  logic [AW-1:0] s1_addr;
  logic [63:0]   s1_data;
  logic [TW-1:0] s1_tag;
  logic          s1_rdy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rvh_l1d_req_arb #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_req_vld_i(ld_vld), .ld_req_rdy_o(ld_rdy), .ld_req_opcode_i(ld_op),
    .ld_req_addr_i(ld_addr), .ld_req_tag_i(ld_tag),
    .st_req_vld_i(st_vld), .st_req_rdy_o(st_rdy), .st_req_opcode_i(st_op),
    .st_req_addr_i(st_addr), .st_req_data_i(st_data), .st_req_tag_i(st_tag),
    .ptw_req_vld_i(ptw_vld), .ptw_req_rdy_o(ptw_rdy), .ptw_req_addr_i(ptw_addr),
    .flush_i(flush),
    .is_ld_req_vld_o(is_ld), .is_st_req_vld_o(is_st), .is_ptw_req_vld_o(is_ptw),
    .s1_ld_opcode_o(s1_ld_op), .s1_st_opcode_o(s1_st_op), .s1_addr_o(s1_addr),
    .s1_data_o(s1_data), .s1_tag_o(s1_tag), .s1_rdy_i(s1_rdy)
  );

  task automatic idle();
    ld_vld = 0; st_vld = 0; ptw_vld = 0; flush = 0;
  endtask

  task automatic set_payloads();
    ld_op = 3'h5; ld_addr = 40'h00_1111_2220; ld_tag = 8'h12;
    st_op = 5'h1b; st_addr = 40'h00_3333_4440; st_data = 64'hdead_beef_cafe_f00d; st_tag = 8'h34;
    ptw_addr = 40'h00_5555_6660;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; set_payloads(); s1_rdy = 1;
    ld_vld = 1; st_vld = 1; ptw_vld = 1; flush = 0;
    #2;
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b000) begin bad++; $display("FAIL reset_vld got=%b exp=000", {is_ld, is_st, is_ptw}); end
    total++;
    if ({s1_ld_op, s1_st_op, s1_addr, s1_data, s1_tag} !== '0) begin bad++; $display("FAIL reset_payload got=%h exp=0", {s1_ld_op, s1_st_op, s1_addr, s1_data, s1_tag}); end
    total++;
    if ({ld_rdy, st_rdy, ptw_rdy} !== 3'b000) begin bad++; $display("FAIL reset_rdy got=%b exp=000", {ld_rdy, st_rdy, ptw_rdy}); end
    idle();
    @(negedge clk); rst_n = 1;
    step();
  endtask

  task automatic test_priority();
    s1_rdy = 1; ld_vld = 1; st_vld = 1; ptw_vld = 1; #1;
    total++;
    if ({ld_rdy, st_rdy, ptw_rdy} !== 3'b001) begin bad++; $display("FAIL prio_rdy0 got=%b exp=001", {ld_rdy, st_rdy, ptw_rdy}); end
    step(); ptw_vld = 0;
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b001 || s1_addr !== ptw_addr) begin bad++; $display("FAIL prio_ptw_out got=%b/%h exp=001/%h", {is_ld, is_st, is_ptw}, s1_addr, ptw_addr); end
    total++;
    if ({s1_ld_op, s1_st_op, s1_data, s1_tag} !== '0) begin bad++; $display("FAIL prio_ptw_zero got=%h exp=0", {s1_ld_op, s1_st_op, s1_data, s1_tag}); end
    #1;
    total++;
    if ({ld_rdy, st_rdy, ptw_rdy} !== 3'b100) begin bad++; $display("FAIL prio_rdy1 got=%b exp=100", {ld_rdy, st_rdy, ptw_rdy}); end
    step(); ld_vld = 0;
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b100 || s1_addr !== ld_addr || s1_tag !== ld_tag || s1_ld_op !== ld_op) begin bad++; $display("FAIL prio_ld_out got=%b/%h/%h/%h exp=100/%h/%h/%h", {is_ld, is_st, is_ptw}, s1_addr, s1_tag, s1_ld_op, ld_addr, ld_tag, ld_op); end
    total++;
    if ({s1_st_op, s1_data} !== '0) begin bad++; $display("FAIL prio_ld_zero got=%h exp=0", {s1_st_op, s1_data}); end
    #1;
    total++;
    if ({ld_rdy, st_rdy, ptw_rdy} !== 3'b010) begin bad++; $display("FAIL prio_rdy2 got=%b exp=010", {ld_rdy, st_rdy, ptw_rdy}); end
    step(); st_vld = 0;
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b010 || s1_addr !== st_addr || s1_data !== st_data || s1_tag !== st_tag || s1_st_op !== st_op || s1_ld_op !== 3'h0) begin bad++; $display("FAIL prio_st_out got=%b/%h/%h/%h/%h exp=010/%h/%h/%h/%h", {is_ld, is_st, is_ptw}, s1_addr, s1_data, s1_tag, s1_st_op, st_addr, st_data, st_tag, st_op); end
    step();
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b000) begin bad++; $display("FAIL prio_empty got=%b exp=000", {is_ld, is_st, is_ptw}); end
  endtask

  task automatic test_stall();
    s1_rdy = 0; ld_vld = 1; ld_tag = 8'h12;
    step(); ld_vld = 0; ptw_vld = 1; st_vld = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({is_ld, is_st, is_ptw} !== 3'b100 || s1_tag !== 8'h12 || s1_addr !== ld_addr) begin bad++; $display("FAIL stall_hold%0d got=%b/%h/%h exp=100/12/%h", i, {is_ld, is_st, is_ptw}, s1_tag, s1_addr, ld_addr); end
      total++;
      if ({ld_rdy, st_rdy, ptw_rdy} !== 3'b000) begin bad++; $display("FAIL stall_rdy%0d got=%b exp=000", i, {ld_rdy, st_rdy, ptw_rdy}); end
      if (i < 2) step();
    end
    s1_rdy = 1; #1;
    total++;
    if ({ld_rdy, st_rdy, ptw_rdy} !== 3'b001) begin bad++; $display("FAIL stall_release_rdy got=%b exp=001", {ld_rdy, st_rdy, ptw_rdy}); end
    step(); idle();
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b001) begin bad++; $display("FAIL stall_release_out got=%b exp=001", {is_ld, is_st, is_ptw}); end
    step();
  endtask

  task automatic test_flush();
    s1_rdy = 0; ld_vld = 1;
    step(); flush = 1; #1;
    total++;
    if (ld_rdy !== 1'b0) begin bad++; $display("FAIL flush_ld_rdy got=%b exp=0", ld_rdy); end
    step();
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b000) begin bad++; $display("FAIL flush_ld_kill got=%b exp=000", {is_ld, is_st, is_ptw}); end
    st_vld = 1; #1;
    total++;
    if ({ld_rdy, st_rdy} !== 2'b01) begin bad++; $display("FAIL flush_st_grant got=%b exp=01", {ld_rdy, st_rdy}); end
    step(); idle(); flush = 1;
    step(); step();
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b010 || s1_data !== st_data) begin bad++; $display("FAIL flush_st_keep got=%b/%h exp=010/%h", {is_ld, is_st, is_ptw}, s1_data, st_data); end
    flush = 0; s1_rdy = 1;
    step();
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b000) begin bad++; $display("FAIL flush_drain got=%b exp=000", {is_ld, is_st, is_ptw}); end
  endtask

  task automatic test_starve();
    logic exp_st;
    s1_rdy = 1; idle(); step();
    ld_vld = 1; st_vld = 1;
    for (int k = 0; k < 10; k++) begin
      #1;
`ifdef RVH_L1D_ARB_STARVE_GUARD_EN
      exp_st = (k % 5 == 4);
`else
      exp_st = 1'b0;
`endif
      total++;
      if ({ld_rdy, st_rdy} !== {~exp_st, exp_st}) begin bad++; $display("FAIL starve_c%0d got=%b exp=%b", k, {ld_rdy, st_rdy}, {~exp_st, exp_st}); end
      step();
    end
    idle(); step();
  endtask

  task automatic test_async_reset();
    s1_rdy = 0; st_vld = 1;
    step(); st_vld = 0;
    total++;
    if (is_st !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b exp=1", is_st); end
    ld_vld = 1; st_vld = 1; s1_rdy = 1;
    #2; rst_n = 0; #1;
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b000 || s1_data !== 64'h0 || s1_addr !== '0) begin bad++; $display("FAIL areset_clear got=%b/%h exp=000/0", {is_ld, is_st, is_ptw}, s1_data); end
    total++;
    if ({ld_rdy, st_rdy, ptw_rdy} !== 3'b000) begin bad++; $display("FAIL areset_rdy got=%b exp=000", {ld_rdy, st_rdy, ptw_rdy}); end
    step();
    @(negedge clk); rst_n = 1; #1;
    total++;
    if ({ld_rdy, st_rdy, ptw_rdy} !== 3'b100) begin bad++; $display("FAIL areset_first_rdy got=%b exp=100", {ld_rdy, st_rdy, ptw_rdy}); end
    step(); idle();
    total++;
    if ({is_ld, is_st, is_ptw} !== 3'b100 || s1_tag !== ld_tag) begin bad++; $display("FAIL areset_first_out got=%b/%h exp=100/%h", {is_ld, is_st, is_ptw}, s1_tag, ld_tag); end
    step();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_stall();
    test_flush();
    test_starve();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rvh_l1d_req_arb.md
RVH_L1D_REQ_ARB -- requirements
Module: rvh_l1d_req_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 40: request physical address width.
REQ-002 SHALL have parameter TAG_WIDTH, default 8: requester tag width.
REQ-003 SHALL have parameter STARVE_MAX, default 4: cycles a pending store may lose arbitration before promotion.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ld_req_vld_i / ld_req_rdy_o  in/out  1/1  load request handshake.
REQ-007 ld_req_opcode_i  in  3  load uop opcode; ld_req_addr_i  in  ADDR_WIDTH; ld_req_tag_i  in  TAG_WIDTH.
REQ-008 st_req_vld_i / st_req_rdy_o  in/out  1/1  store/AMO request handshake.
REQ-009 st_req_opcode_i  in  5  store uop opcode; st_req_addr_i  in  ADDR_WIDTH; st_req_data_i  in  64; st_req_tag_i  in  TAG_WIDTH.
REQ-010 ptw_req_vld_i / ptw_req_rdy_o  in/out  1/1  page-table-walk request handshake; ptw_req_addr_i  in  ADDR_WIDTH.
REQ-011 flush_i  in  1  pipeline flush; kills loads only.
REQ-012 is_ld_req_vld_o, is_st_req_vld_o, is_ptw_req_vld_o  out  1 each  registered stage valids, feed the request decoder.
REQ-013 s1_ld_opcode_o  out  3; s1_st_opcode_o  out  5; s1_addr_o  out  ADDR_WIDTH; s1_data_o  out  64; s1_tag_o  out  TAG_WIDTH.
REQ-014 s1_rdy_i  in  1  downstream stage accepts the held request this cycle.

Function
REQ-015 SHALL hold one request in a single output register; at most one of the three is_*_req_vld_o asserted.
REQ-016 Register free = no valid held, or held valid with s1_rdy_i=1 (same-cycle replace; throughput 1 req/cycle).
REQ-017 When free and not flushing a load, SHALL grant exactly one valid requester, default priority PTW > LD > ST.
REQ-018 *_rdy_o SHALL be combinational: 1 only for the granted requester in a free cycle; transfer = vld & rdy.
REQ-019 Granted payload SHALL be latched next edge; fields unused by the granted type (e.g. s1_st_opcode_o, s1_data_o for loads) SHALL be zero; PTW tag zero, opcodes zero.
REQ-020 Held request SHALL stay stable while valid and s1_rdy_i=0; no new grant.
REQ-021 flush_i=1: a held load SHALL be cleared next edge regardless of s1_rdy_i; ld_req_rdy_o SHALL be 0; held ST/PTW unaffected; ST/PTW may still be granted if free.
REQ-022 No requester valid while free: register becomes empty next edge.
REQ-023 Latency: request accepted in cycle N appears on outputs in cycle N+1.

Reset
REQ-024 rst_n low SHALL immediately clear all is_*_req_vld_o, all s1_* payload outputs to 0, and the starvation counter to 0; *_rdy_o low while in reset.
REQ-025 Reset asserted mid-transfer SHALL discard the held request; no transfer completes in that cycle.

Configuration
REQ-026 Macro RVH_L1D_ARB_STARVE_GUARD_EN defined: counter (clog2(STARVE_MAX+1) bits) increments each cycle st_req_vld_i=1 and store not granted, saturating at STARVE_MAX.
REQ-027 With macro, counter==STARVE_MAX SHALL make ST top priority (ST > PTW > LD) until store granted; counter clears on store grant or st_req_vld_i=0.
REQ-028 Macro undefined: no counter, pure fixed priority PTW > LD > ST.

Verification
REQ-029 ld/st/ptw valid simultaneously, s1_rdy_i=1 -> ptw granted cycle 0, ld cycle 1, st cycle 2; outputs lag one cycle.
REQ-030 held load tag 0x12, s1_rdy_i=0 for 3 cycles then 1 -> outputs stable 3 cycles, all *_rdy_o=0, release on 4th.
REQ-031 held load + flush_i=1, s1_rdy_i=0 -> is_ld_req_vld_o=0 next cycle; held store same scenario -> remains valid.
REQ-032 guard enabled, STARVE_MAX=4, ld and st valid continuously -> 4 loads granted, then store granted, counter returns 0.
REQ-033 guard disabled, same stimulus -> store never granted while ld_req_vld_i=1.
REQ-034 rst_n dropped asynchronously with store held -> all valids 0 before next edge; after release first grant follows REQ-017.
